// File: rtl/cfg_regfile_apb.sv
// APB4 configuration register file: CTRL/STATUS/IRQ_EN block followed by NUM_REGS generic words.
// Define CFG_SHADOW_EN to drive cfg_out from a bank captured on each accepted start.
module cfg_regfile_apb #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 24,
  parameter logic [NUM_REGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                           PCLK,
  input  logic                           PRESET,
  input  logic [ADDR_WIDTH-1:0]          PADDR,
  input  logic                           PSEL,
  input  logic                           PENABLE,
  input  logic                           PWRITE,
  input  logic [DATA_WIDTH-1:0]          PWDATA,
  input  logic [DATA_WIDTH/8-1:0]        PSTRB,
  output logic [DATA_WIDTH-1:0]          PRDATA,
  output logic                           PREADY,
  output logic                           PSLVERR,
  output logic [NUM_REGS*DATA_WIDTH-1:0] cfg_out,
  output logic                           start_tpu,
  output logic                           pe_reset,
  output logic                           busy,
  output logic                           irq,
  input  logic                           done_tpu
);

  localparam int unsigned IdxW  = ADDR_WIDTH - 2;
  localparam int unsigned StrbW = DATA_WIDTH / 8;
  localparam logic [IdxW-1:0] IdxCtrl   = IdxW'(0);
  localparam logic [IdxW-1:0] IdxStatus = IdxW'(1);
  localparam logic [IdxW-1:0] IdxIrqEn  = IdxW'(2);
  localparam logic [IdxW-1:0] LastIdx   = IdxW'(NUM_REGS + 2);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] gen_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] gen_d [NUM_REGS];
  logic [DATA_WIDTH-1:0] prdata_q, prdata_d, rdata;
  logic                  pready_q, pready_d, pslverr_q, pslverr_d;
  logic                  start_q, start_d, pe_reset_q, pe_reset_d;
  logic                  busy_q, busy_d, done_q, done_d, overrun_q, overrun_d;
  logic [1:0]            irq_en_q, irq_en_d;
  logic                  irq_q, irq_d;

  logic [IdxW-1:0] idx;
  logic            addr_err, in_access, wr_ok;
  logic            ctrl_wr, status_wr, irqen_wr, start_req, done_set;

  assign idx       = PADDR[ADDR_WIDTH-1:2];
  assign addr_err  = (PADDR[1:0] != 2'b00) || (idx > LastIdx);
  assign in_access = (state_q == StAccess);
  assign wr_ok     = in_access && PWRITE && !addr_err;
  assign ctrl_wr   = wr_ok && (idx == IdxCtrl);
  assign status_wr = wr_ok && (idx == IdxStatus);
  assign irqen_wr  = wr_ok && (idx == IdxIrqEn);
  assign start_req = ctrl_wr && PWDATA[0];
  // done only counts while a run is in progress; a start is only accepted while idle
  assign done_set  = busy_q && done_tpu;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (PSEL && !PENABLE) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    rdata = '0;
    if (idx == IdxStatus) rdata[2:0] = {overrun_q, done_q, busy_q};
    if (idx == IdxIrqEn)  rdata[1:0] = irq_en_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == IdxW'(i + 3)) rdata = gen_q[i];
    end
  end

  always_comb begin
    prdata_d   = '0;
    pslverr_d  = in_access && addr_err;
    pready_d   = in_access;
    if (in_access && !PWRITE && !addr_err) prdata_d = rdata;

    start_d    = start_req && !busy_q;
    pe_reset_d = ctrl_wr && PWDATA[15];
    busy_d     = start_d ? 1'b1 : (done_set ? 1'b0 : busy_q);
    // W1C clears lose against a set on the same edge
    done_d     = done_set | (done_q & ~(status_wr & PWDATA[1]));
    overrun_d  = (start_req && busy_q) | (overrun_q & ~(status_wr & PWDATA[2]));
    irq_en_d   = irqen_wr ? PWDATA[1:0] : irq_en_q;
    irq_d      = (done_d & irq_en_d[0]) | (overrun_d & irq_en_d[1]);

    gen_d = gen_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (wr_ok && (idx == IdxW'(i + 3))) begin
        for (int b = 0; b < StrbW; b++) begin
          if (PSTRB[b]) gen_d[i][b*8 +: 8] = PWDATA[b*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q    <= StIdle;
      prdata_q   <= '0;
      pready_q   <= 1'b0;
      pslverr_q  <= 1'b0;
      start_q    <= 1'b0;
      pe_reset_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) gen_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
    end else begin
      state_q    <= state_d;
      prdata_q   <= prdata_d;
      pready_q   <= pready_d;
      pslverr_q  <= pslverr_d;
      start_q    <= start_d;
      pe_reset_q <= pe_reset_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      gen_q      <= gen_d;
    end
  end

`ifdef CFG_SHADOW_EN
  logic [DATA_WIDTH-1:0] shadow_q [NUM_REGS];

  // Captured on the edge that raises start_tpu so the running layer sees a stable set
  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
    end else if (start_d) begin
      shadow_q <= gen_q;
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_cfg_out
    assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = shadow_q[g];
  end
`else
  for (genvar g = 0; g < NUM_REGS; g++) begin : gen_cfg_out
    assign cfg_out[g*DATA_WIDTH +: DATA_WIDTH] = gen_q[g];
  end
`endif

  assign PRDATA    = prdata_q;
  assign PREADY    = pready_q;
  assign PSLVERR   = pslverr_q;
  assign start_tpu = start_q;
  assign pe_reset  = pe_reset_q;
  assign busy      = busy_q;
  assign irq       = irq_q;

endmodule

// File: tb/tb_cfg_regfile_apb.sv
// Directed self-checking bench for cfg_regfile_apb (default parameters, word 0 resets to 0x8).
module tb_cfg_regfile_apb;

  localparam int unsigned NR = 24;
  localparam logic [NR*32-1:0] RV = {{(NR*32-32){1'b0}}, 32'h0000_0008};

  logic            PCLK = 1'b0;
  logic            PRESET;
  logic [9:0]      PADDR;
  logic            PSEL, PENABLE, PWRITE;
  logic [31:0]     PWDATA;
  logic [3:0]      PSTRB;
  logic [31:0]     PRDATA;
  logic            PREADY, PSLVERR;
  logic [NR*32-1:0] cfg_out;
  logic            start_tpu, pe_reset, busy, irq, done_tpu;

  cfg_regfile_apb #(
    .ADDR_WIDTH  (10),
    .DATA_WIDTH  (32),
    .NUM_REGS    (NR),
    .RESET_VALUES(RV)
  ) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .PADDR    (PADDR),
    .PSEL     (PSEL),
    .PENABLE  (PENABLE),
    .PWRITE   (PWRITE),
    .PWDATA   (PWDATA),
    .PSTRB    (PSTRB),
    .PRDATA   (PRDATA),
    .PREADY   (PREADY),
    .PSLVERR  (PSLVERR),
    .cfg_out  (cfg_out),
    .start_tpu(start_tpu),
    .pe_reset (pe_reset),
    .busy     (busy),
    .irq      (irq),
    .done_tpu (done_tpu)
  );

  always #5 PCLK = ~PCLK;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] g_rdata;
  logic        g_err, g_start, g_pe;
  int          g_lat;
  logic        done_in_access = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One transfer: setup, access, then wait (bounded) for PREADY; samples #1 after each edge.
  task automatic apb_xfer(input logic wr, input logic [9:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = data; PSTRB = strb;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    if (done_in_access) done_tpu = 1'b1;
    g_lat = 1;
    g_start = 1'b0; g_pe = 1'b0; g_rdata = '0; g_err = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge PCLK); #1;
      done_tpu = 1'b0;
      g_lat++;
      if (PREADY) break;
    end
    if (!PREADY) check("pready_timeout", {31'b0, PREADY}, 32'h1);
    g_rdata = PRDATA; g_err = PSLVERR; g_start = start_tpu; g_pe = pe_reset;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic apb_write(input logic [9:0] addr, input logic [31:0] data, input logic [3:0] strb);
    apb_xfer(1'b1, addr, data, strb);
  endtask

  task automatic apb_read(input logic [9:0] addr);
    apb_xfer(1'b0, addr, 32'h0, 4'h0);
  endtask

  task automatic pulse_done();
    @(posedge PCLK); #1; done_tpu = 1'b1;
    @(posedge PCLK); #1; done_tpu = 1'b0;
    @(posedge PCLK); #1;
  endtask

  initial begin
    PRESET = 1'b1; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PADDR = '0;
    PWDATA = '0; PSTRB = '0; done_tpu = 1'b0;
    repeat (3) @(posedge PCLK);
    #1 PRESET = 1'b0;

    // Reset state
    check("rst_pready", {31'b0, PREADY}, 32'h0);
    check("rst_pslverr", {31'b0, PSLVERR}, 32'h0);
    check("rst_prdata", PRDATA, 32'h0);
    check("rst_busy_irq", {29'b0, busy, irq, start_tpu}, 32'h0);
    check("rst_cfg0", cfg_out[31:0], 32'h8);

    apb_read(10'h00C);
    check("gen0_rst_data", g_rdata, 32'h8);
    check("gen0_rst_err", {31'b0, g_err}, 32'h0);

    // Byte strobes
    apb_write(10'h010, 32'hAABB_CCDD, 4'b0101);
    check("strb_latency", g_lat, 2);
    check("strb_wr_err", {31'b0, g_err}, 32'h0);
`ifdef CFG_SHADOW_EN
    check("strb_cfg1", cfg_out[63:32], 32'h0);
`else
    check("strb_cfg1", cfg_out[63:32], 32'h00BB_00DD);
`endif
    apb_read(10'h010);
    check("strb_read", g_rdata, 32'h00BB_00DD);
    check("strb_rd_latency", g_lat, 2);

    // Error responses
    apb_read(10'h002);
    check("misalign_err", {31'b0, g_err}, 32'h1);
    check("misalign_data", g_rdata, 32'h0);
    apb_write(10'h00E, 32'hFFFF_FFFF, 4'hF);
    check("misalign_wr_err", {31'b0, g_err}, 32'h1);
    apb_read(10'h06C);
    check("oob_err", {31'b0, g_err}, 32'h1);
    check("oob_data", g_rdata, 32'h0);
    apb_write(10'h06C, 32'h1234_5678, 4'hF);
    check("oob_wr_err", {31'b0, g_err}, 32'h1);
    apb_read(10'h00C);
    check("no_change_gen0", g_rdata, 32'h8);
    apb_read(10'h068);
    check("last_idx_err", {31'b0, g_err}, 32'h0);
    check("last_idx_data", g_rdata, 32'h0);

    // IRQ_EN
    apb_write(10'h008, 32'hFFFF_FFF1, 4'h0);
    apb_read(10'h008);
    check("irq_en_read", g_rdata, 32'h1);

    // Start handshake
    apb_write(10'h000, 32'h1, 4'hF);
    check("start_pulse", {31'b0, g_start}, 32'h1);
    check("start_busy", {31'b0, busy}, 32'h1);
    @(posedge PCLK); #1;
    check("start_one_cycle", {31'b0, start_tpu}, 32'h0);
    apb_read(10'h000);
    check("ctrl_reads_zero", g_rdata, 32'h0);
    apb_read(10'h004);
    check("status_busy", g_rdata, 32'h1);

    // GEN write while busy
    apb_write(10'h00C, 32'h55, 4'hF);
`ifdef CFG_SHADOW_EN
    check("shadow_cfg0", cfg_out[31:0], 32'h8);
`else
    check("direct_cfg0", cfg_out[31:0], 32'h55);
`endif
    apb_read(10'h00C);
    check("gen0_live", g_rdata, 32'h55);

    // Overrun
    apb_write(10'h000, 32'h1, 4'hF);
    check("overrun_no_pulse", {31'b0, g_start}, 32'h0);
    apb_read(10'h004);
    check("status_overrun", g_rdata, 32'h5);

    // Completion and interrupt
    pulse_done();
    check("done_busy_clr", {31'b0, busy}, 32'h0);
    check("done_irq", {31'b0, irq}, 32'h1);
    apb_read(10'h004);
    check("status_done", g_rdata, 32'h6);
    apb_write(10'h004, 32'h2, 4'h0);
    @(posedge PCLK); #1;
    check("w1c_irq", {31'b0, irq}, 32'h0);
    apb_read(10'h004);
    check("w1c_status", g_rdata, 32'h4);

    // W1C colliding with done_tpu: set wins
    apb_write(10'h000, 32'h1, 4'hF);
    check("restart_pulse", {31'b0, g_start}, 32'h1);
    done_in_access = 1'b1;
    apb_write(10'h004, 32'h2, 4'hF);
    done_in_access = 1'b0;
    apb_read(10'h004);
    check("w1c_collide", g_rdata, 32'h6);
    check("collide_irq", {31'b0, irq}, 32'h1);

    // PE reset pulses, independent of and combinable with start
    apb_write(10'h004, 32'h6, 4'hF);
    apb_write(10'h000, 32'h8001, 4'hF);
    check("both_start", {31'b0, g_start}, 32'h1);
    check("both_pe", {31'b0, g_pe}, 32'h1);
    apb_write(10'h000, 32'h8000, 4'hF);
    check("pe_only_pe", {31'b0, g_pe}, 32'h1);
    check("pe_only_start", {31'b0, g_start}, 32'h0);
    apb_read(10'h004);
    check("pe_no_overrun", g_rdata, 32'h1);
    @(posedge PCLK); #1;
    check("pe_one_cycle", {31'b0, pe_reset}, 32'h0);
    pulse_done();

    // Reset during ACCESS aborts the write
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 10'h014; PWDATA = 32'h1234; PSTRB = 4'hF;
    @(posedge PCLK); #1;
    PENABLE = 1'b1; PRESET = 1'b1;
    @(posedge PCLK); #1;
    check("abort_pready", {31'b0, PREADY}, 32'h0);
    check("abort_irq", {31'b0, irq}, 32'h0);
    PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0;
    apb_read(10'h014);
    check("abort_no_write", g_rdata, 32'h0);
    apb_read(10'h00C);
    check("abort_gen0_rst", g_rdata, 32'h8);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cfg_regfile_apb.md
# cfg_regfile_apb

Parametrised successor to the TPU configuration slave: an APB4 register file with a generic bank of `NUM_REGS` configuration words, byte strobes, error response on unmapped or misaligned addresses, and a control/status block. It adds sticky W1C done/overrun status, an interrupt, and start-latched shadow copies. Sits between the host APB bus and the TPU core. `cfg_out` feeds the core's per-layer parameters; `start_tpu`/`done_tpu` drive the core handshake.

## Interface
- `ADDR_WIDTH`, 10: APB address width; byte addresses, word-aligned.
- `DATA_WIDTH`, 32: register and bus width; a multiple of 8.
- `NUM_REGS`, 24: number of generic config words; at least 1, and `NUM_REGS` + 3 must fit in `ADDR_WIDTH`-2 bits.
- `RESET_VALUES`, 0: `NUM_REGS*DATA_WIDTH` vector; word i resets to slice i.
- `PCLK`, in, 1: sole clock; all logic on the rising edge.
- `PRESET`, in, 1: synchronous, active-high reset.
- `PADDR`, in, `ADDR_WIDTH`: byte address.
- `PSEL`, `PENABLE`, `PWRITE`, in, 1 each: APB control.
- `PWDATA`, in, `DATA_WIDTH`: write data.
- `PSTRB`, in, `DATA_WIDTH`/8: byte write enables.
- `PRDATA`, out, `DATA_WIDTH`: read data; registered.
- `PREADY`, out, 1: transfer complete; registered.
- `PSLVERR`, out, 1: error response; registered, meaningful only while `PREADY`=1.
- `cfg_out`, out, `NUM_REGS*DATA_WIDTH`: config words; word i is at bits [i*DATA_WIDTH +: DATA_WIDTH].
- `start_tpu`, out, 1: one-cycle start pulse to the core.
- `pe_reset`, out, 1: one-cycle PE reset pulse.
- `busy`, out, 1: core run in progress.
- `irq`, out, 1: level interrupt.
- `done_tpu`, in, 1: core completion, sampled while `busy`.

## Operation
- Word index = `PADDR`[ADDR_WIDTH-1:2]. Register map:
  - Index 0, CTRL: write-only pulses; reads return 0.
  - Index 1, STATUS: bit0 busy (RO), bit1 done (W1C), bit2 overrun (W1C).
  - Index 2, IRQ_EN: bits[1:0]; bit0 enables done, bit1 enables overrun.
  - Index 3..3+NUM_REGS-1: GEN[i].
- Error: PSLVERR=1 when `PADDR`[1:0]≠0 or the index exceeds 2+NUM_REGS. On error, writes have no effect and PRDATA=0.
- GEN writes update only the bytes whose `PSTRB` bit is set. CTRL, STATUS and IRQ_EN ignore `PSTRB`.
- CTRL write with bit0=1:
  - If `busy`=0: `start_tpu` pulses one cycle and `busy` is set.
  - If `busy`=1: no pulse and STATUS.overrun is set.
- CTRL write with bit15=1: `pe_reset` pulses one cycle. This is independent of bit0; both may pulse in the same cycle.
- `done_tpu`=1 while `busy`=1: `busy` clears and STATUS.done sets on the next edge. `done_tpu` while idle is ignored.
- Simultaneous done-set and W1C clear of done: set wins. The same rule applies to overrun.
- `irq` = (done & IRQ_EN[0]) | (overrun & IRQ_EN[1]), registered.
- A start and a `done_tpu` in the same cycle cannot coexist: a start is only accepted when `busy`=0.

## Timing
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS on `PSEL` & !`PENABLE`.
  - ACCESS → RESP unconditionally. At the end of ACCESS the write is committed, PRDATA and PSLVERR are loaded, and PREADY<=1.
  - RESP → IDLE. PREADY<=0, PSLVERR<=0, PRDATA<=0.
- This gives one wait state: setup, ACCESS (PREADY=0), RESP (PREADY=1), so 3 cycles per transfer. A new setup phase may occur in the cycle after RESP.
- `start_tpu`, `pe_reset`, `busy` and the GEN values are first visible in the RESP cycle.
- Reads in RESP return the pre-write state of the same transfer's edge. That is, STATUS reflects all events up to the end of ACCESS.
- Reset values:
  - FSM = IDLE.
  - PRDATA=0, PREADY=0, PSLVERR=0.
  - `start_tpu`=0, `pe_reset`=0, `busy`=0, `irq`=0.
  - STATUS=0, IRQ_EN=0.
  - GEN = `RESET_VALUES`; `cfg_out` = `RESET_VALUES`.
- `PRESET` mid-transfer aborts the transfer. No write is committed on the reset edge, and the master sees PREADY=0 on the next cycle.

## Configuration
- `CFG_SHADOW_EN` defined:
  - `cfg_out` is driven from a shadow bank that copies all GEN words on the same edge `start_tpu` is asserted.
  - GEN writes while `busy` do not disturb the running layer.
  - Reads of GEN return the live (host) copy.
- `CFG_SHADOW_EN` undefined: `cfg_out` is wired directly to GEN, with no shadow storage.

## Test plan
- Reset with `RESET_VALUES` word 0 = 0x8: read index 3 → PRDATA=0x8, PSLVERR=0; `cfg_out`[31:0]=0x8.
- Write 0xAABBCCDD to index 4 with PSTRB=4'b0101, prior value 0: read returns 0x00BB00DD; PREADY high exactly 2 cycles after the setup cycle.
- Read `PADDR`=0x002 (misaligned) and index 3+NUM_REGS: PSLVERR=1, PRDATA=0; no register changes.
- CTRL=0x1: `start_tpu` pulses 1 cycle and `busy`=1. Second CTRL=0x1 sets overrun with no pulse. `done_tpu` pulse clears `busy` and sets done; with IRQ_EN=0x1, `irq`=1. W1C 0x2 clears done and `irq`, while overrun remains set.
- W1C of done in the same cycle `done_tpu` arrives: done stays 1.
- With `CFG_SHADOW_EN`: start, then write GEN[0]=0x55 while `busy`: `cfg_out` word 0 keeps its old value, and a read of GEN[0] returns 0x55.
